// File: rtl/if_stage_fetch.sv
// if_stage_fetch: PC register, next-PC select, IF/ID pipeline register and saturating stall/flush counters.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             if_flush,
  input  logic             cnt_clr,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_pc4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};
  logic [31:0]      pc_q, pc_d, pc4;
  logic [31:0]      pc4_q, pc4_d, instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             flush_load;
  always_comb begin
    pc4        = pc_q + 32'd4;
    pc_d       = !pc_write ? pc_q : branch_taken ? {branch_target[31:2], 2'b00} : pc4;
    flush_load = if_id_write && if_flush;
    pc4_d      = if_id_write ? pc4 : pc4_q;
    instr_d    = !if_id_write ? instr_q : if_flush ? NOP_INSTR : imem_rdata;
    valid_d    = if_id_write ? !if_flush : valid_q;
    stall_d    = cnt_clr ? '0 : (!pc_write && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d    = cnt_clr ? '0 : (flush_load && flush_q != '1) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_RST;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign imem_addr   = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
endmodule

// File: tb/tb_if_stage_fetch.sv
// tb_if_stage_fetch: directed vector table plus hand-written wrap, saturation and async-reset sequences.
module tb_if_stage_fetch;
  localparam logic [31:0] K = 32'h5A00_0000;
  logic        clk = 1'b0;
  logic        rst_n, pw, iw, bt, fl, clr;
  logic [31:0] tgt, addr, rdata, pc4, instr;
  logic        valid;
  logic [15:0] scnt, fcnt;
  logic        rst2_n, pw2, iw2, clr2;
  logic [31:0] addr2, rdata2, pc4_2, instr2;
  logic        valid2;
  logic [1:0]  scnt2, fcnt2;
  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;
  assign rdata  = addr ^ K;
  assign rdata2 = addr2 ^ K;

  if_stage_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pw), .if_id_write(iw), .branch_taken(bt),
    .branch_target(tgt), .if_flush(fl), .cnt_clr(clr), .imem_addr(addr), .imem_rdata(rdata),
    .if_id_pc4(pc4), .if_id_instr(instr), .if_id_valid(valid), .stall_cnt(scnt), .flush_cnt(fcnt)
  );

  if_stage_fetch #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst2_n), .pc_write(pw2), .if_id_write(iw2), .branch_taken(1'b0),
    .branch_target(32'h0), .if_flush(1'b0), .cnt_clr(clr2), .imem_addr(addr2), .imem_rdata(rdata2),
    .if_id_pc4(pc4_2), .if_id_instr(instr2), .if_id_valid(valid2), .stall_cnt(scnt2), .flush_cnt(fcnt2)
  );

  typedef struct {
    logic        pw, iw, bt, fl, clr;
    logic [31:0] tgt, e_pc, e_pc4, e_instr;
    logic        e_v;
    logic [15:0] e_s, e_f;
  } vec_t;
  vec_t v[17];

  function automatic vec_t mk(logic p, logic i, logic b, logic f, logic c, logic [31:0] t,
                              logic [31:0] epc, logic [31:0] ep4, logic [31:0] ein, logic ev,
                              logic [15:0] es, logic [15:0] ef);
    vec_t r;
    r.pw = p; r.iw = i; r.bt = b; r.fl = f; r.clr = c; r.tgt = t;
    r.e_pc = epc; r.e_pc4 = ep4; r.e_instr = ein; r.e_v = ev; r.e_s = es; r.e_f = ef;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_main(string tag, logic [31:0] epc, logic [31:0] ep4, logic [31:0] ein,
                          logic ev, logic [15:0] es, logic [15:0] ef);
    chk({tag, " pc"}, addr, epc);
    chk({tag, " pc4"}, pc4, ep4);
    chk({tag, " instr"}, instr, ein);
    chk({tag, " valid"}, {31'b0, valid}, {31'b0, ev});
    chk({tag, " stall_cnt"}, {16'b0, scnt}, {16'b0, es});
    chk({tag, " flush_cnt"}, {16'b0, fcnt}, {16'b0, ef});
  endtask

  // A PC advance while IF/ID holds would drop an instruction; the stimulus must never do it.
  always @(posedge clk) begin
    if (rst_n) begin
      ncmp++;
      if (pw && !iw) begin
        nfail++;
        $display("FAIL illegal_ctrl: got pc_write=1 if_id_write=0 expected never");
      end
    end
  end

  initial begin
    v[0]  = mk(1,1,0,0,0, 32'h0,   32'h004, 32'h004, K^32'h000, 1, 0, 0);
    v[1]  = mk(1,1,0,0,0, 32'h0,   32'h008, 32'h008, K^32'h004, 1, 0, 0);
    v[2]  = mk(1,1,0,0,0, 32'h0,   32'h00C, 32'h00C, K^32'h008, 1, 0, 0);
    v[3]  = mk(1,1,0,0,0, 32'h0,   32'h010, 32'h010, K^32'h00C, 1, 0, 0);
    v[4]  = mk(0,0,0,0,0, 32'h0,   32'h010, 32'h010, K^32'h00C, 1, 1, 0);
    v[5]  = mk(1,1,0,0,0, 32'h0,   32'h014, 32'h014, K^32'h010, 1, 1, 0);
    v[6]  = mk(1,1,0,0,0, 32'h0,   32'h018, 32'h018, K^32'h014, 1, 1, 0);
    v[7]  = mk(1,1,0,0,0, 32'h0,   32'h01C, 32'h01C, K^32'h018, 1, 1, 0);
    v[8]  = mk(1,1,0,0,0, 32'h0,   32'h020, 32'h020, K^32'h01C, 1, 1, 0);
    v[9]  = mk(1,1,1,1,0, 32'h103, 32'h100, 32'h024, 32'h0,     0, 1, 1);
    v[10] = mk(1,1,0,0,0, 32'h0,   32'h104, 32'h104, K^32'h100, 1, 1, 1);
    v[11] = mk(0,0,1,1,0, 32'h200, 32'h104, 32'h104, K^32'h100, 1, 2, 1);
    v[12] = mk(1,1,1,1,0, 32'h200, 32'h200, 32'h108, 32'h0,     0, 2, 2);
    v[13] = mk(1,1,0,0,0, 32'h0,   32'h204, 32'h204, K^32'h200, 1, 2, 2);
    v[14] = mk(1,1,0,0,1, 32'h0,   32'h208, 32'h208, K^32'h204, 1, 0, 0);
    v[15] = mk(1,1,0,1,0, 32'h0,   32'h20C, 32'h20C, 32'h0,     0, 0, 1);
    v[16] = mk(1,1,1,0,0, 32'h302, 32'h300, 32'h210, K^32'h20C, 1, 0, 1);

    rst_n = 0; pw = 1; iw = 1; bt = 0; fl = 0; clr = 0; tgt = 0;
    rst2_n = 0; pw2 = 1; iw2 = 1; clr2 = 0;
    repeat (2) @(negedge clk);
    chk_main("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      pw = v[i].pw; iw = v[i].iw; bt = v[i].bt; fl = v[i].fl; clr = v[i].clr; tgt = v[i].tgt;
      @(posedge clk);
      #1;
      chk_main($sformatf("vec%0d", i), v[i].e_pc, v[i].e_pc4, v[i].e_instr, v[i].e_v, v[i].e_s, v[i].e_f);
    end
    pw = 1; iw = 1; bt = 0; fl = 0; clr = 0; tgt = 0;

    @(negedge clk);
    chk("wrap reset pc", addr2, 32'hFFFF_FFF8);
    rst2_n = 1;
    @(posedge clk); #1;
    chk("wrap pc1", addr2, 32'hFFFF_FFFC);
    chk("wrap instr1", instr2, K ^ 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk("wrap pc2", addr2, 32'h0000_0000);
    chk("wrap pc4_2", pc4_2, 32'h0000_0000);
    @(posedge clk); #1;
    chk("wrap pc3", addr2, 32'h0000_0004);
    pw2 = 0; iw2 = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat stall%0d", i), {30'b0, scnt2}, (i < 3) ? i : 3);
    end
    chk("sat pc hold", addr2, 32'h0000_0004);
    clr2 = 1;
    @(posedge clk); #1;
    chk("sat clr", {30'b0, scnt2}, 32'h0);
    clr2 = 0; pw2 = 1; iw2 = 1;
    @(posedge clk); #1;
    chk("sat after clr", {30'b0, scnt2}, 32'h0);
    chk("sat flush", {30'b0, fcnt2}, 32'h0);

    pw = 0; iw = 0;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk_main("async", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1; pw = 1; iw = 1;
    @(posedge clk); #1;
    chk_main("restart", 32'h4, 32'h4, K ^ 32'h0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
